// File: rtl/alu_pkg.sv
// Shared types and constants for the issue-side ALU decode slice.
package alu_pkg;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    // ALU control codes, identical to the EX-stage ALU encoding
    localparam logic [5:0] ALUC_SLL  = 6'b000000;
    localparam logic [5:0] ALUC_SRL  = 6'b000010;
    localparam logic [5:0] ALUC_SRA  = 6'b000011;
    localparam logic [5:0] ALUC_SLLV = 6'b000100;
    localparam logic [5:0] ALUC_SRLV = 6'b000110;
    localparam logic [5:0] ALUC_SRAV = 6'b000111;
    localparam logic [5:0] ALUC_JR   = 6'b001000;
    localparam logic [5:0] ALUC_LUI  = 6'b001111;
    localparam logic [5:0] ALUC_ADD  = 6'b100000;
    localparam logic [5:0] ALUC_ADDU = 6'b100001;
    localparam logic [5:0] ALUC_SUB  = 6'b100010;
    localparam logic [5:0] ALUC_SUBU = 6'b100011;
    localparam logic [5:0] ALUC_AND  = 6'b100100;
    localparam logic [5:0] ALUC_OR   = 6'b100101;
    localparam logic [5:0] ALUC_XOR  = 6'b100110;
    localparam logic [5:0] ALUC_NOR  = 6'b100111;
    localparam logic [5:0] ALUC_SLT  = 6'b101010;
    localparam logic [5:0] ALUC_SLTU = 6'b101011;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // One decoded micro-op as held in the skid FIFO
    typedef struct packed {
        logic [5:0]      aluc;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] pc;
        logic [4:0]      wreg;
        logic            wen;
        logic            illegal;
    } uop_t;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
        return {{(XLEN-16){imm[15]}}, imm};
    endfunction

    function automatic logic [XLEN-1:0] zext16(input logic [15:0] imm);
        return {{(XLEN-16){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/alu_uop_decode.sv
// Combinational MIPS decode: instruction + register data -> ALU micro-op.
module alu_uop_decode
    import alu_pkg::*;
(
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic [XLEN-1:0] pc,
    output uop_t            uop
);

    logic [5:0]  opcode;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    // The rs index is consumed upstream by the register file read
    logic        unused_rs_idx;

    assign opcode        = instr[31:26];
    assign rt_idx        = instr[20:16];
    assign rd_idx        = instr[15:11];
    assign shamt         = instr[10:6];
    assign funct         = instr[5:0];
    assign imm           = instr[15:0];
    assign unused_rs_idx = ^instr[25:21];

    // Map opcode/funct to ALU code, operand sources and writeback target
    always_comb begin
        uop         = '0;
        uop.pc      = pc;
        uop.aluc    = ALUC_ADDU;
        uop.illegal = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR,
                    FN_NOR, FN_SLT, FN_SLTU, FN_SLLV, FN_SRLV, FN_SRAV: begin
                        uop.aluc = funct;
                        uop.a    = rs_data;
                        uop.b    = rt_data;
                        uop.wreg = rd_idx;
                        uop.wen  = 1'b1;
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        // The ALU shifts by all of a, so shamt must be zero-extended
                        uop.aluc = funct;
                        uop.a    = {{(XLEN-5){1'b0}}, shamt};
                        uop.b    = rt_data;
                        uop.wreg = rd_idx;
                        uop.wen  = 1'b1;
                    end
                    FN_JR: begin
                        uop.aluc = ALUC_JR;
                        uop.a    = rs_data;
                    end
                    default: uop.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                uop.a    = rs_data;
                uop.wreg = rt_idx;
                uop.wen  = 1'b1;
                unique case (opcode)
                    OP_ADDI:  begin uop.aluc = ALUC_ADD;  uop.b = sext16(imm); end
                    OP_ADDIU: begin uop.aluc = ALUC_ADDU; uop.b = sext16(imm); end
                    OP_SLTI:  begin uop.aluc = ALUC_SLT;  uop.b = sext16(imm); end
                    OP_SLTIU: begin uop.aluc = ALUC_SLTU; uop.b = sext16(imm); end
                    OP_ANDI:  begin uop.aluc = ALUC_AND;  uop.b = zext16(imm); end
                    OP_ORI:   begin uop.aluc = ALUC_OR;   uop.b = zext16(imm); end
                    default:  begin uop.aluc = ALUC_XOR;  uop.b = zext16(imm); end
                endcase
            end
            OP_LUI: begin
                uop.aluc = ALUC_LUI;
                uop.b    = zext16(imm);
                uop.wreg = rt_idx;
                uop.wen  = 1'b1;
            end
            OP_LW: begin
                uop.aluc = ALUC_ADDU;
                uop.a    = rs_data;
                uop.b    = sext16(imm);
                uop.wreg = rt_idx;
                uop.wen  = 1'b1;
            end
            OP_SW: begin
                uop.aluc = ALUC_ADDU;
                uop.a    = rs_data;
                uop.b    = sext16(imm);
            end
            OP_BEQ, OP_BNE: begin
                uop.aluc = ALUC_SUBU;
                uop.a    = rs_data;
                uop.b    = rt_data;
            end
            default: uop.illegal = 1'b1;
        endcase
        // Illegal entries still flow down so EX can trap at the right PC
        if (uop.illegal) begin
            uop.aluc = ALUC_ADDU;
            uop.a    = '0;
            uop.b    = '0;
            uop.wreg = '0;
            uop.wen  = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_decode.sv
// Issue-side producer: decodes ID instructions and buffers them in a 2-entry skid FIFO.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      out_aluc,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_wreg,
    output logic            out_wen,
    output logic            out_illegal
);

    uop_t       dec_uop;
    uop_t       entry_q [DEPTH];
    uop_t       entry_d [DEPTH];
    uop_t       head;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       in_ready_q, in_ready_d;
    logic       push, pop;

    alu_uop_decode u_decode (
        .instr   (in_instr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .pc      (in_pc),
        .uop     (dec_uop)
    );

    // in_ready is registered, so a full FIFO never accepts even when popping
    assign push = in_valid & in_ready_q & ~flush;
    assign pop  = (count_q != 2'd0) & out_ready & ~flush;

    // Write the decoded uop into the tail slot on push
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (push) begin
            entry_d[wr_ptr_q] = dec_uop;
        end
    end

    // Pointer, occupancy and ready bookkeeping; flush empties everything
    always_comb begin
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            wr_ptr_d = wr_ptr_q ^ push;
            rd_ptr_d = rd_ptr_q ^ pop;
            count_d  = count_q + {1'b0, push} - {1'b0, pop};
        end
        in_ready_d = (count_d != 2'd2);
    end

    // State registers with synchronous reset; storage is cleared so outputs read 0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign head        = entry_q[rd_ptr_q];
    assign in_ready    = in_ready_q;
    assign out_valid   = (count_q != 2'd0);
    assign out_aluc    = head.aluc;
    assign out_a       = head.a;
    assign out_b       = head.b;
    assign out_pc      = head.pc;
    assign out_wreg    = head.wreg;
    assign out_wen     = head.wen;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_alu_issue_decode.sv
// Self-checking bench for alu_issue_decode: queue-based model plus directed pins.
module tb_alu_issue_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_aluc;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [31:0] out_pc;
    logic [4:0]  out_wreg;
    logic        out_wen;
    logic        out_illegal;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [5:0]  aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [4:0]  wreg;
        logic        wen;
        logic        ill;
    } exp_t;

    exp_t mdl_q[$];
    bit   mdl_rdy = 1'b1;

    alu_issue_decode dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_aluc    (out_aluc),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_pc      (out_pc),
        .out_wreg    (out_wreg),
        .out_wen     (out_wen),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Expected micro-op straight from the instruction-set rules
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] ze;
        logic [31:0] se;
        op = ins[31:26];
        fn = ins[5:0];
        ze = {16'h0000, ins[15:0]};
        se = ins[15] ? (ze | 32'hFFFF0000) : ze;
        e = '{aluc: 6'h21, a: 32'h0, b: 32'h0, pc: pc, wreg: 5'd0, wen: 1'b0, ill: 1'b1};
        if (op == 6'h00) begin
            if (fn inside {[6'h20:6'h27], 6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07})
                e = '{fn, rs, rt, pc, ins[15:11], 1'b1, 1'b0};
            else if (fn inside {6'h00, 6'h02, 6'h03})
                e = '{fn, {27'b0, ins[10:6]}, rt, pc, ins[15:11], 1'b1, 1'b0};
            else if (fn == 6'h08)
                e = '{6'h08, rs, 32'h0, pc, 5'd0, 1'b0, 1'b0};
        end else begin
            case (op)
                6'h08: e = '{6'h20, rs, se, pc, ins[20:16], 1'b1, 1'b0};
                6'h09: e = '{6'h21, rs, se, pc, ins[20:16], 1'b1, 1'b0};
                6'h0A: e = '{6'h2A, rs, se, pc, ins[20:16], 1'b1, 1'b0};
                6'h0B: e = '{6'h2B, rs, se, pc, ins[20:16], 1'b1, 1'b0};
                6'h0C: e = '{6'h24, rs, ze, pc, ins[20:16], 1'b1, 1'b0};
                6'h0D: e = '{6'h25, rs, ze, pc, ins[20:16], 1'b1, 1'b0};
                6'h0E: e = '{6'h26, rs, ze, pc, ins[20:16], 1'b1, 1'b0};
                6'h0F: e = '{6'h0F, 32'h0, ze, pc, ins[20:16], 1'b1, 1'b0};
                6'h23: e = '{6'h21, rs, se, pc, ins[20:16], 1'b1, 1'b0};
                6'h2B: e = '{6'h21, rs, se, pc, 5'd0, 1'b0, 1'b0};
                6'h04, 6'h05: e = '{6'h23, rs, rt, pc, 5'd0, 1'b0, 1'b0};
                default: ;
            endcase
        end
        return e;
    endfunction

    // Model advance on every rising edge using the inputs the DUT also sees
    always @(posedge clk) begin
        bit push;
        bit pop;
        push = in_valid && mdl_rdy && !flush;
        pop  = (mdl_q.size() > 0) && out_ready && !flush;
        if (rst || flush) begin
            mdl_q.delete();
            mdl_rdy = 1'b1;
        end else begin
            if (pop) void'(mdl_q.pop_front());
            if (push) mdl_q.push_back(model(in_instr, in_pc, rs_data, rt_data));
            mdl_rdy = (mdl_q.size() < 2);
        end
    end

    // Single compare process, sampling on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("out_valid", {31'b0, out_valid}, {31'b0, mdl_q.size() > 0});
            cmp("in_ready", {31'b0, in_ready}, {31'b0, mdl_rdy});
            if (out_valid && mdl_q.size() > 0) begin
                cmp("aluc", {26'b0, out_aluc}, {26'b0, mdl_q[0].aluc});
                cmp("a", out_a, mdl_q[0].a);
                cmp("b", out_b, mdl_q[0].b);
                cmp("pc", out_pc, mdl_q[0].pc);
                cmp("wen", {31'b0, out_wen}, {31'b0, mdl_q[0].wen});
                cmp("illegal", {31'b0, out_illegal}, {31'b0, mdl_q[0].ill});
                if (mdl_q[0].wen) cmp("wreg", {27'b0, out_wreg}, {27'b0, mdl_q[0].wreg});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] rs, input logic [31:0] rt);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        rs_data  = rs;
        rt_data  = rt;
    endtask

    task automatic check_reset_values(input string tag);
        cmp({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
        cmp({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
        cmp({tag, "_aluc"}, {26'b0, out_aluc}, 32'd0);
        cmp({tag, "_a"}, out_a, 32'd0);
        cmp({tag, "_b"}, out_b, 32'd0);
        cmp({tag, "_pc"}, out_pc, 32'd0);
        cmp({tag, "_wreg"}, {27'b0, out_wreg}, 32'd0);
        cmp({tag, "_wen"}, {31'b0, out_wen}, 32'd0);
        cmp({tag, "_ill"}, {31'b0, out_illegal}, 32'd0);
    endtask

    // Push one instruction into an empty FIFO, pin its decoded fields, then drain it
    task automatic directed(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                            input logic [31:0] rs, input logic [31:0] rt,
                            input logic [5:0] aluc, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] wreg, input logic wen, input logic ill);
        drive(ins, pc, rs, rt);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        cmp({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        cmp({tag, "_aluc"}, {26'b0, out_aluc}, {26'b0, aluc});
        cmp({tag, "_a"}, out_a, a);
        cmp({tag, "_b"}, out_b, b);
        cmp({tag, "_pc"}, out_pc, pc);
        cmp({tag, "_wen"}, {31'b0, out_wen}, {31'b0, wen});
        cmp({tag, "_ill"}, {31'b0, out_illegal}, {31'b0, ill});
        if (wen) cmp({tag, "_wreg"}, {27'b0, out_wreg}, {27'b0, wreg});
        $display("directed %s: instr=%h aluc=%b a=%h b=%h", tag, ins, out_aluc, out_a, out_b);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        int          k;
        logic [31:0] w;
        logic [5:0]  fn;
        logic [5:0]  op;
        k = $urandom_range(0, 15);
        w = $urandom;
        case ($urandom_range(0, 17))
            0: fn = 6'h20;  1: fn = 6'h21;  2: fn = 6'h22;  3: fn = 6'h23;
            4: fn = 6'h24;  5: fn = 6'h25;  6: fn = 6'h26;  7: fn = 6'h27;
            8: fn = 6'h2A;  9: fn = 6'h2B;  10: fn = 6'h00; 11: fn = 6'h02;
            12: fn = 6'h03; 13: fn = 6'h04; 14: fn = 6'h06; 15: fn = 6'h07;
            16: fn = 6'h08;
            default: fn = w[5:0];
        endcase
        if (k <= 4)       op = 6'h00;
        else if (k <= 12) op = 6'(k + 3);
        else if (k == 13) op = ($urandom_range(0, 1) == 0) ? 6'h23 : 6'h2B;
        else if (k == 14) op = ($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05;
        else              op = w[31:26];
        return {op, w[25:6], (op == 6'h00) ? fn : w[5:0]};
    endfunction

    initial begin
        // Reset with flush also held
        rst = 1'b1;
        flush = 1'b1;
        step();
        step();
        rst = 1'b0;
        flush = 1'b0;
        check_reset_values("reset");
        chk_en = 1'b1;

        directed("addi", 32'h2109FFFC, 32'h0000_1000, 32'd10, 32'h0, 6'b100000, 32'd10, 32'hFFFFFFFC, 5'd9, 1'b1, 1'b0);
        directed("sll",  32'h00031100, 32'h0000_1004, 32'hDEAD, 32'h1, 6'b000000, 32'h4, 32'h1, 5'd2, 1'b1, 1'b0);
        directed("lui",  32'h3C051234, 32'h0000_1008, 32'h55, 32'h66, 6'b001111, 32'h0, 32'h00001234, 5'd5, 1'b1, 1'b0);
        directed("andi", 32'h3108FF00, 32'h0000_100C, 32'h7, 32'h0, 6'b100100, 32'h7, 32'h0000FF00, 5'd8, 1'b1, 1'b0);
        directed("slti", 32'h28418000, 32'h0000_1010, 32'h3, 32'h0, 6'b101010, 32'h3, 32'hFFFF8000, 5'd1, 1'b1, 1'b0);
        directed("illegal", 32'h7C000000, 32'h0000_0040, 32'h3, 32'h4, 6'b100001, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        directed("jr",   32'h03E00008, 32'h0000_1014, 32'h1000, 32'h9, 6'b001000, 32'h1000, 32'h0, 5'd0, 1'b0, 1'b0);

        // Backpressure: two accepted, third held until a slot frees
        out_ready = 1'b0;
        drive(32'h21090001, 32'h100, 32'h1, 32'h2);
        step();
        cmp("bp_ready1", {31'b0, in_ready}, 32'd1);
        cmp("bp_head1", out_pc, 32'h100);
        drive(32'h21090002, 32'h104, 32'h3, 32'h4);
        step();
        cmp("bp_ready2", {31'b0, in_ready}, 32'd0);
        drive(32'h21090003, 32'h108, 32'h5, 32'h6);
        step();
        step();
        cmp("bp_held_ready", {31'b0, in_ready}, 32'd0);
        cmp("bp_held_head", out_pc, 32'h100);
        out_ready = 1'b1;
        step();
        cmp("bp_pop1_head", out_pc, 32'h104);
        cmp("bp_pop1_ready", {31'b0, in_ready}, 32'd1);
        step();
        cmp("bp_third_head", out_pc, 32'h108);
        in_valid = 1'b0;
        step();
        cmp("bp_drained", {31'b0, out_valid}, 32'd0);
        $display("backpressure sequence done");

        // Flush with a full FIFO and a same-cycle input that must be dropped
        out_ready = 1'b0;
        drive(32'h21090010, 32'h300, 32'h1, 32'h1);
        step();
        drive(32'h21090011, 32'h304, 32'h1, 32'h1);
        step();
        drive(32'h21090012, 32'h308, 32'h1, 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        cmp("flush_valid", {31'b0, out_valid}, 32'd0);
        cmp("flush_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            cmp("flush_dropped", {31'b0, out_valid}, 32'd0);
        end
        $display("flush sequence done");

        // Randomised traffic against the queue model
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            in_instr  = rand_instr();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            rs_data   = $urandom;
            rt_data   = $urandom;
            step();
            if (n % 500 == 0)
                $display("random cycle %0d: queued=%0d checks=%0d", n, mdl_q.size(), checks);
        end
        rst = 1'b0;
        flush = 1'b0;

        // Fill, then reset and flush together
        out_ready = 1'b0;
        drive(32'h3C0FABCD, 32'h500, 32'h1, 32'h1);
        step();
        step();
        rst = 1'b1;
        flush = 1'b1;
        step();
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        check_reset_values("rst_flush");
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
